regs_read_sequencer: RTL and testbench

//  Sequences two-operand reads (rs1, rs2) through the register file's single

---
 rtl/regs_pkg.sv | 12 +
 rtl/regseq_fwd.sv | 34 +++
 rtl/regs_read_sequencer.sv | 140 ++++++++++++++
 tb/tb_regs_read_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared types and sizes for the register read sequencer.
//   XLEN            operand / register data width
//   REG_ADDR_W      register index width
//   regseq_state_t  sequencer FSM state
//   reg_idx_t       register index
package regs_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {IDLE, RD1, RD2, DONE} regseq_state_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regseq_fwd.sv
// Combinational writeback compare plus operand select.
// Flags a writeback to a non-zero index equal to idx, and optionally
// substitutes the writeback data for rd_data on a hit.
// Ports:
//   wb_en, wb_sel, wb_data  writeback request this cycle
//   idx                     register index being read / held
//   rd_data                 value otherwise used for that register
//   hit                     writeback targets idx (never for x0)
//   data                    selected value (bypassed only when BYPASS=1)
module regseq_fwd
  import regs_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_sel,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [REG_ADDR_W-1:0] idx,
  input  logic [XLEN-1:0]       rd_data,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);
  // x0 is hardwired to zero, so a write to it never matches.
  assign hit = wb_en && (wb_sel != '0) && (wb_sel == idx);

  if (BYPASS) begin : g_byp
    assign data = hit ? wb_data : rd_data;
  end else begin : g_nobyp
    // No bypass: the caller stalls and re-reads instead.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign data = rd_data;
  end
endmodule

// File: rtl/regs_read_sequencer.sv
// Sequences rs1/rs2 reads through the register file's single combinational
// read port, then presents both operands to execute; also drives the
// register file write port (idle cycles write x0, which is harmless).
// Optional feature macro: REGS_READ_SEQ_FWD_EN
//   defined     same-cycle writeback to the register being read is bypassed
//   not defined the FSM holds one extra cycle in RD1/RD2 and re-reads
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     decode request handshake, req_rs1/req_rs2 indices
//   op_valid/op_ready       execute handshake, op1/op2 operand values
//   wb_en/wb_sel/wb_data    writeback request
//   reg1_select/reg1        register file read port
//   reg_write_select/_data  register file write port
module regs_read_sequencer
  import regs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [REG_ADDR_W-1:0] req_rs1,
  input  logic [REG_ADDR_W-1:0] req_rs2,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [XLEN-1:0]       op1,
  output logic [XLEN-1:0]       op2,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_sel,
  input  logic [XLEN-1:0]       wb_data,
  output logic [REG_ADDR_W-1:0] reg1_select,
  input  logic [XLEN-1:0]       reg1,
  output logic [REG_ADDR_W-1:0] reg_write_select,
  output logic [XLEN-1:0]       reg_write_data
);
`ifdef REGS_READ_SEQ_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  regseq_state_t   state_q;
  reg_idx_t        rs1_q, rs2_q;
  logic [XLEN-1:0] op1_q, op2_q;

  logic            cap_hit, co1_hit, co2_hit;
  logic [XLEN-1:0] cap_data, co1_data, co2_data;
  logic            stall;

  // Write port is never stalled; idle cycles target x0.
  assign reg_write_select = wb_en ? wb_sel  : '0;
  assign reg_write_data   = wb_en ? wb_data : '0;

  always_comb begin
    reg1_select = '0;
    case (state_q)
      RD1:     reg1_select = rs1_q;
      RD2:     reg1_select = rs2_q;
      default: reg1_select = '0;
    endcase
  end

  // Read capture: reg1_select is 0 outside RD1/RD2, so cap_hit can only
  // fire while a read is in flight.
  regseq_fwd #(.BYPASS(FWD_EN)) u_cap (
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .idx(reg1_select), .rd_data(reg1),
    .hit(cap_hit), .data(cap_data)
  );

  // Coherence for already-latched operands.
  regseq_fwd #(.BYPASS(1'b1)) u_co1 (
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .idx(rs1_q), .rd_data(op1_q),
    .hit(co1_hit), .data(co1_data)
  );

  regseq_fwd #(.BYPASS(1'b1)) u_co2 (
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .idx(rs2_q), .rd_data(op2_q),
    .hit(co2_hit), .data(co2_data)
  );

  // The hit flags of the coherence paths only steer their own mux.
  logic unused_co_hit;
  assign unused_co_hit = co1_hit ^ co2_hit;

  // Without bypass, a same-cycle write to the register being read would be
  // missed (it lands at the edge), so hold and read again next cycle.
  assign stall = !FWD_EN && cap_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            state_q <= RD1;
          end
        end
        RD1: begin
          if (!stall) begin
            op1_q <= cap_data;
            if (rs2_q == rs1_q) begin
              op2_q   <= cap_data;
              state_q <= DONE;
            end else begin
              state_q <= RD2;
            end
          end
        end
        RD2: begin
          // op1 is already held; keep it current while rs2 is read.
          op1_q <= co1_data;
          if (!stall) begin
            op2_q   <= cap_data;
            state_q <= DONE;
          end
        end
        DONE: begin
          op1_q <= co1_data;
          op2_q <= co2_data;
          if (op_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign op_valid  = (state_q == DONE);
  assign op1       = op1_q;
  assign op2       = op2_q;
endmodule

// File: tb/tb_regs_read_sequencer.sv
module tb_regs_read_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs1, req_rs2;
  logic        op_valid, op_ready;
  logic [31:0] op1, op2;
  logic        wb_en;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic [4:0]  reg1_select;
  logic [31:0] reg1;
  logic [4:0]  reg_write_select;
  logic [31:0] reg_write_data;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef REGS_READ_SEQ_FWD_EN
  localparam int HAZ_LAT = 3;
`else
  localparam int HAZ_LAT = 4;
`endif

  always #5 clk = ~clk;

  regs_read_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op1(op1), .op2(op2),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .reg1_select(reg1_select), .reg1(reg1),
    .reg_write_select(reg_write_select), .reg_write_data(reg_write_data)
  );

  // Register file model: combinational read, write at the edge, x0 = 0.
  logic [31:0] rf [32];
  always @(posedge clk)
    if (reg_write_select != 5'd0) rf[reg_write_select] <= reg_write_data;
  assign reg1 = (reg1_select == 5'd0) ? 32'd0 : rf[reg1_select];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    wb_en = 1'b1; wb_sel = idx; wb_data = d;
    step();
    wb_en = 1'b0; wb_sel = '0; wb_data = '0;
  endtask

  // Present a request this cycle and clock it in; n = cycles since accept.
  task automatic issue(input logic [4:0] a, input logic [4:0] b);
    req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int start, output int n);
    n = start;
    while (!op_valid && n < 12) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_cmp++; if (op_valid !== 1'b0) begin n_bad++; $display("FAIL reset_op_valid got %0b want 0", op_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
    n_cmp++; if (op1 !== 32'd0 || op2 !== 32'd0) begin n_bad++; $display("FAIL reset_ops got %h/%h want 0/0", op1, op2); end
    n_cmp++; if (reg1_select !== 5'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", reg1_select); end
    reset = 1'b0;
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got %0b want 1", req_ready); end
  endtask

  task automatic test_basic();
    wr(5'd5, 32'h11);
    wr(5'd6, 32'h22);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %0b want 1", req_ready); end
    issue(5'd5, 5'd6);
    n_cmp++; if (reg1_select !== 5'd5 || op_valid !== 1'b0) begin n_bad++; $display("FAIL basic_rd1 sel %0d vld %0b want 5/0", reg1_select, op_valid); end
    step();
    n_cmp++; if (reg1_select !== 5'd6 || op_valid !== 1'b0) begin n_bad++; $display("FAIL basic_rd2 sel %0d vld %0b want 6/0", reg1_select, op_valid); end
    step();
    n_cmp++; if (op_valid !== 1'b1) begin n_bad++; $display("FAIL basic_lat op_valid got %0b want 1 at N+3", op_valid); end
    n_cmp++; if (op1 !== 32'h11 || op2 !== 32'h22) begin n_bad++; $display("FAIL basic_ops got %h/%h want 11/22", op1, op2); end
    n_cmp++; if (reg1_select !== 5'd0) begin n_bad++; $display("FAIL basic_done_sel got %0d want 0", reg1_select); end
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    n_cmp++; if (op_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL basic_consume vld %0b rdy %0b want 0/1", op_valid, req_ready); end
  endtask

  task automatic test_same_reg();
    wr(5'd7, 32'hABCD);
    issue(5'd7, 5'd7);
    n_cmp++; if (reg1_select !== 5'd7) begin n_bad++; $display("FAIL same_rd1 sel got %0d want 7", reg1_select); end
    step();
    n_cmp++; if (op_valid !== 1'b1) begin n_bad++; $display("FAIL same_lat op_valid got %0b want 1 at N+2", op_valid); end
    n_cmp++; if (op1 !== 32'hABCD || op2 !== 32'hABCD) begin n_bad++; $display("FAIL same_ops got %h/%h want abcd/abcd", op1, op2); end
    op_ready = 1'b1; step(); op_ready = 1'b0;
  endtask

  task automatic test_hazard();
    int n;
    issue(5'd5, 5'd6);
    n_cmp++; if (reg1_select !== 5'd5) begin n_bad++; $display("FAIL haz_rd1 sel got %0d want 5", reg1_select); end
    wb_en = 1'b1; wb_sel = 5'd5; wb_data = 32'h99;
    step();
    wb_en = 1'b0; wb_sel = '0; wb_data = '0;
    wait_valid(2, n);
    n_cmp++; if (n !== HAZ_LAT) begin n_bad++; $display("FAIL haz_lat got %0d want %0d", n, HAZ_LAT); end
    n_cmp++; if (op1 !== 32'h99 || op2 !== 32'h22) begin n_bad++; $display("FAIL haz_ops got %h/%h want 99/22", op1, op2); end
    op_ready = 1'b1; step(); op_ready = 1'b0;
  endtask

  task automatic test_done_coherence();
    int n;
    issue(5'd5, 5'd6);
    wait_valid(1, n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL coh_lat got %0d want 3", n); end
    wr(5'd6, 32'h55);
    n_cmp++; if (op_valid !== 1'b1 || op2 !== 32'h55 || op1 !== 32'h99) begin n_bad++; $display("FAIL coh_ops vld %0b got %h/%h want 1 99/55", op_valid, op1, op2); end
    step();
    n_cmp++; if (op_valid !== 1'b1 || op2 !== 32'h55) begin n_bad++; $display("FAIL coh_hold vld %0b op2 %h want 1/55", op_valid, op2); end
    op_ready = 1'b1; step(); op_ready = 1'b0;
    n_cmp++; if (op_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL coh_release vld %0b rdy %0b want 0/1", op_valid, req_ready); end
  endtask

  task automatic test_x0();
    int n;
    step();
    n_cmp++; if (reg_write_select !== 5'd0 || reg_write_data !== 32'd0) begin n_bad++; $display("FAIL idle_wr got %0d/%h want 0/0", reg_write_select, reg_write_data); end
    wb_en = 1'b1; wb_sel = 5'd9; wb_data = 32'h77;
    #1;
    n_cmp++; if (reg_write_select !== 5'd9 || reg_write_data !== 32'h77) begin n_bad++; $display("FAIL wr_port got %0d/%h want 9/77", reg_write_select, reg_write_data); end
    wb_en = 1'b0; wb_sel = '0; wb_data = '0;
    issue(5'd0, 5'd6);
    wb_en = 1'b1; wb_sel = 5'd0; wb_data = 32'hDEAD;
    step();
    wb_en = 1'b0; wb_data = '0;
    wait_valid(2, n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL x0_lat got %0d want 3", n); end
    n_cmp++; if (op1 !== 32'd0 || op2 !== 32'h55) begin n_bad++; $display("FAIL x0_ops got %h/%h want 0/55", op1, op2); end
    op_ready = 1'b1; step(); op_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    issue(5'd5, 5'd6);
    step();
    n_cmp++; if (reg1_select !== 5'd6) begin n_bad++; $display("FAIL mid_rd2 sel got %0d want 6", reg1_select); end
    reset = 1'b1;
    step();
    n_cmp++; if (op_valid !== 1'b0 || op1 !== 32'd0 || op2 !== 32'd0) begin n_bad++; $display("FAIL mid_reset vld %0b ops %h/%h want 0 0/0", op_valid, op1, op2); end
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_idle ready got %0b want 1", req_ready); end
    issue(5'd5, 5'd6);
    wait_valid(1, n);
    n_cmp++; if (n !== 3 || op1 !== 32'h99 || op2 !== 32'h55) begin n_bad++; $display("FAIL mid_redo lat %0d ops %h/%h want 3 99/55", n, op1, op2); end
    op_ready = 1'b1; step(); op_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
    op_ready = 1'b0; wb_en = 1'b0; wb_sel = '0; wb_data = '0;
    test_reset();
    test_basic();
    test_same_reg();
    test_hazard();
    test_done_coherence();
    test_x0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
